// File: rtl/elbeth_dmem_ctrl_pkg.sv
// Shared elbeth definitions for the data-memory controller:
// access-size codes, FSM state encoding and lane helper functions.
package elbeth_dmem_ctrl_pkg;

    localparam logic [3:0] SIZE_BYTE = 4'b0001;
    localparam logic [3:0] SIZE_HALF = 4'b0010;
    localparam logic [3:0] SIZE_WORD = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } dmem_state_e;

    // Unknown size codes report as misaligned so they never reach the bus.
    function automatic logic is_aligned(
        input logic [3:0] size,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (size == SIZE_BYTE): ok = 1'b1;
            (size == SIZE_HALF): ok = ~off[0];
            (size == SIZE_WORD): ok = (off == 2'b00);
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_en(
        input logic [3:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (1'b1)
            (size == SIZE_BYTE): be = 4'b0001 << off;
            (size == SIZE_HALF): be = 4'b0011 << off;
            (size == SIZE_WORD): be = 4'b1111;
            default:             be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes; byte enables pick the live one.
    function automatic logic [31:0] lane_data(
        input logic [3:0]  size,
        input logic [31:0] wd
    );
        logic [31:0] d;
        d = wd;
        unique case (1'b1)
            (size == SIZE_BYTE): d = {4{wd[7:0]}};
            (size == SIZE_HALF): d = {2{wd[15:0]}};
            default:             d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/elbeth_dmem_ctrl_if.sv
// Memory-bus bundle between the data-memory controller and memory.
// master: controller side (drives request); slave: memory side.
interface elbeth_dmem_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/elbeth_dmem_ctrl_load_align.sv
// Load lane select plus sign/zero extension (combinational).
// Ports: word/addr/size/is_signed in, data out.
module elbeth_load_align
    import elbeth_dmem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [3:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{addr, 3'b000} +: 8];
        h    = addr[1] ? word[31:16] : word[15:0];
        data = 32'h0;
        unique case (1'b1)
            (size == SIZE_BYTE): data = {{24{is_signed & b[7]}}, b};
            (size == SIZE_HALF): data = {{16{is_signed & h[15]}}, h};
            (size == SIZE_WORD): data = word;
            default:             data = 32'h0;
        endcase
    end

endmodule

// File: rtl/elbeth_dmem_ctrl.sv
// Data-memory controller: pipeline load/store to a req/ack bus.
// Ports: clk, rst_n, pipeline req/rsp/exc signals, mem bus (master).
module elbeth_dmem_ctrl
    import elbeth_dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  ctrl_data_size,
    input  logic        ctrl_data_signed,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        exc_misaligned,
    output logic        exc_bus_error,
    elbeth_dmem_ctrl_if.master mem
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W:0] TMO = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0] ONE = (CNT_W + 1)'(1);

    dmem_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic [1:0]       lat_off;
    logic [3:0]       lat_size;
    logic             lat_sext;
    logic [31:0]      ld_data;
    logic             aligned;
    logic             accept;
    logic             done;
    logic             tmo_hit;

    assign aligned = is_aligned(ctrl_data_size, req_addr[1:0]);
    assign cnt_inc = {1'b0, cnt} + ONE;

    // Combinational outputs are gated so reset forces them low too.
    assign stall = rst_n &
        (((state == ST_IDLE) & req_valid & aligned) |
         (state == ST_ACCESS));
    assign exc_misaligned = rst_n &
        (state == ST_IDLE) & req_valid & ~aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid && aligned) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_RESPOND;
                end else if (cnt_inc >= TMO) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESPOND: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    elbeth_load_align u_align (
        .word      (mem.mem_rdata),
        .addr      (lat_off),
        .size      (lat_size),
        .is_signed (lat_sext),
        .data      (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            lat_off         <= 2'b00;
            lat_size        <= 4'h0;
            lat_sext        <= 1'b0;
            mem.mem_req     <= 1'b0;
            mem.mem_we      <= 1'b0;
            mem.mem_addr    <= 32'h0;
            mem.mem_wdata   <= 32'h0;
            mem.mem_byte_en <= 4'h0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= 32'h0;
            exc_bus_error   <= 1'b0;
        end else begin
            rsp_valid     <= 1'b0;
            exc_bus_error <= 1'b0;
            if (accept) begin
                cnt             <= '0;
                lat_off         <= req_addr[1:0];
                lat_size        <= ctrl_data_size;
                lat_sext        <= ctrl_data_signed;
                mem.mem_req     <= 1'b1;
                mem.mem_we      <= req_write;
                mem.mem_addr    <= {req_addr[31:2], 2'b00};
                mem.mem_wdata   <= lane_data(ctrl_data_size, req_wdata);
                mem.mem_byte_en <= lane_en(ctrl_data_size, req_addr[1:0]);
            end
            if (state == ST_ACCESS && !mem.mem_ack) begin
                cnt <= cnt_inc[CNT_W-1:0];
            end
            if (done) begin
                mem.mem_req <= 1'b0;
                rsp_valid   <= 1'b1;
                // mem_we still holds the latched direction here.
                rsp_rdata   <= mem.mem_we ? 32'h0 : ld_data;
            end
            if (tmo_hit) begin
                mem.mem_req   <= 1'b0;
                exc_bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_elbeth_dmem_ctrl.sv
// Self-checking bench for elbeth_dmem_ctrl: vector table plus
// hand sequences for timeout and mid-access reset.
module tb_elbeth_dmem_ctrl;
    import elbeth_dmem_ctrl_pkg::*;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  size;
        logic        sext;
        logic [31:0] rdata;
        int          lat;
        logic        mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  ctrl_data_size;
    logic        ctrl_data_signed;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        exc_misaligned;
    logic        exc_bus_error;

    elbeth_dmem_ctrl_if mem_if ();

    elbeth_dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .ctrl_data_size   (ctrl_data_size),
        .ctrl_data_signed (ctrl_data_signed),
        .stall            (stall),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .exc_misaligned   (exc_misaligned),
        .exc_bus_error    (exc_bus_error),
        .mem              (mem_if.master)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    vec_t        vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every response pops the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
            end else begin
                sb_exp = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, sb_exp);
            end
        end
    end

    task automatic add(input string nm, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sz, input logic sx,
                       input logic [31:0] rd, input int lat,
                       input logic mis, input logic [3:0] be,
                       input logic [31:0] ma, input logic [31:0] mw,
                       input logic [31:0] er);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.wdata = wd;
        v.size = sz; v.sext = sx; v.rdata = rd; v.lat = lat;
        v.mis = mis; v.exp_be = be; v.exp_maddr = ma;
        v.exp_wdata = mw; v.exp_rdata = er;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr = v.addr;
        req_wdata = v.wdata;
        ctrl_data_size = v.size;
        ctrl_data_signed = v.sext;
        #1;
        if (v.mis) begin
            check({v.name, ":mis_pulse"}, 32'(exc_misaligned), 32'd1);
            check({v.name, ":mis_stall"}, 32'(stall), 32'd0);
            check({v.name, ":mis_req0"}, 32'(mem_if.mem_req), 32'd0);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check({v.name, ":mis_once"}, 32'(exc_misaligned), 32'd0);
            check({v.name, ":mis_req1"}, 32'(mem_if.mem_req), 32'd0);
        end else begin
            check({v.name, ":stall_req"}, 32'(stall), 32'd1);
            check({v.name, ":no_mis"}, 32'(exc_misaligned), 32'd0);
            exp_q.push_back(v.wr ? 32'h0 : v.exp_rdata);
            @(negedge clk);
            req_valid = 1'b0;
            req_write = ~v.wr;
            req_addr = $urandom;
            req_wdata = $urandom;
            ctrl_data_signed = ~v.sext;
            mem_if.mem_rdata = $urandom;
            #1;
            check({v.name, ":mem_req"}, 32'(mem_if.mem_req), 32'd1);
            check({v.name, ":mem_we"}, 32'(mem_if.mem_we), 32'(v.wr));
            check({v.name, ":mem_addr"}, mem_if.mem_addr, v.exp_maddr);
            check({v.name, ":byte_en"}, 32'(mem_if.mem_byte_en),
                  32'(v.exp_be));
            if (v.wr)
                check({v.name, ":mem_wdata"}, mem_if.mem_wdata,
                      v.exp_wdata);
            check({v.name, ":stall_acc"}, 32'(stall), 32'd1);
            for (int i = 0; i < v.lat; i++) begin
                @(negedge clk);
                #1;
                check({v.name, ":req_hold"}, 32'(mem_if.mem_req), 32'd1);
                check({v.name, ":addr_hold"}, mem_if.mem_addr,
                      v.exp_maddr);
                check({v.name, ":stall_hold"}, 32'(stall), 32'd1);
            end
            mem_if.mem_ack = 1'b1;
            mem_if.mem_rdata = v.rdata;
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
            mem_if.mem_rdata = $urandom;
            #1;
            check({v.name, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({v.name, ":req_drop"}, 32'(mem_if.mem_req), 32'd0);
            check({v.name, ":stall_rsp"}, 32'(stall), 32'd0);
            @(negedge clk);
            #1;
            check({v.name, ":rsp_once"}, 32'(rsp_valid), 32'd0);
            check({v.name, ":sb_drain"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        ctrl_data_size = SIZE_WORD;
        ctrl_data_signed = 1'b0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = 32'h0;

        add("ld_b_s_103", 0, 32'h103, 0, SIZE_BYTE, 1, 32'h80AB_CDEF,
            0, 0, 4'b1000, 32'h100, 0, 32'hFFFF_FF80);
        add("ld_h_u_202", 0, 32'h202, 0, SIZE_HALF, 0, 32'h9234_5678,
            1, 0, 4'b1100, 32'h200, 0, 32'h0000_9234);
        add("ld_h_s_202", 0, 32'h202, 0, SIZE_HALF, 1, 32'h9234_5678,
            0, 0, 4'b1100, 32'h200, 0, 32'hFFFF_9234);
        add("st_b_41", 1, 32'h41, 32'h0000_00A5, SIZE_BYTE, 0,
            32'h5555_AAAA, 2, 0, 4'b0010, 32'h40, 32'hA5A5_A5A5, 0);
        add("mis_w_06", 0, 32'h06, 0, SIZE_WORD, 0, 0,
            0, 1, 0, 0, 0, 0);
        add("ld_w_300", 0, 32'h300, 0, SIZE_WORD, 1, 32'hDEAD_BEEF,
            0, 0, 4'b1111, 32'h300, 0, 32'hDEAD_BEEF);
        add("st_h_12", 1, 32'h12, 32'h1234_BEEF, SIZE_HALF, 1,
            32'h0, 1, 0, 4'b1100, 32'h10, 32'hBEEF_BEEF, 0);
        add("ld_b_u_101", 0, 32'h101, 0, SIZE_BYTE, 0, 32'h1234_F678,
            0, 0, 4'b0010, 32'h100, 0, 32'h0000_00F6);
        add("ld_b_s_101", 0, 32'h101, 0, SIZE_BYTE, 1, 32'h1234_F678,
            0, 0, 4'b0010, 32'h100, 0, 32'hFFFF_FFF6);
        add("mis_h_03", 0, 32'h03, 0, SIZE_HALF, 0, 0,
            0, 1, 0, 0, 0, 0);
        add("bad_size", 0, 32'h0, 0, 4'b1000, 0, 0,
            0, 1, 0, 0, 0, 0);
        add("st_w_20", 1, 32'h20, 32'hCAFE_F00D, SIZE_WORD, 0,
            32'h1, 0, 0, 4'b1111, 32'h20, 32'hCAFE_F00D, 0);
        add("ld_h_s_200", 0, 32'h200, 0, SIZE_HALF, 1, 32'h1234_7FFF,
            0, 0, 4'b0011, 32'h200, 0, 32'h0000_7FFF);
        add("ld_b_s_ffc", 0, 32'hFFC, 0, SIZE_BYTE, 1, 32'h0000_0081,
            1, 0, 4'b0001, 32'hFFC, 0, 32'hFFFF_FF81);
        add("mis_st_w_2", 1, 32'h2, 32'h1, SIZE_WORD, 0, 0,
            0, 1, 0, 0, 0, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst:stall", 32'(stall), 32'd0);
        check("rst:mem_req", 32'(mem_if.mem_req), 32'd0);
        check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst:mem_addr", mem_if.mem_addr, 32'h0);
        check("rst:byte_en", 32'(mem_if.mem_byte_en), 32'd0);
        check("rst:exc_bus", 32'(exc_bus_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Timeout with no ack, then a stray ack in IDLE.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h80;
        ctrl_data_size = SIZE_WORD;
        #1;
        check("tmo:stall", 32'(stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check("tmo:req_hold", 32'(mem_if.mem_req), 32'd1);
            check("tmo:no_exc", 32'(exc_bus_error), 32'd0);
        end
        @(negedge clk);
        #1;
        check("tmo:exc", 32'(exc_bus_error), 32'd1);
        check("tmo:req_drop", 32'(mem_if.mem_req), 32'd0);
        check("tmo:no_rsp", 32'(rsp_valid), 32'd0);
        check("tmo:stall0", 32'(stall), 32'd0);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        #1;
        check("tmo:exc_once", 32'(exc_bus_error), 32'd0);
        check("stray_ack:req", 32'(mem_if.mem_req), 32'd0);
        check("stray_ack:rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("stray_ack:rsp2", 32'(rsp_valid), 32'd0);

        // Reset pulled low mid-access.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h44;
        req_wdata = 32'h1122_3344;
        ctrl_data_size = SIZE_WORD;
        @(negedge clk);
        #1;
        check("mid:req_on", 32'(mem_if.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid:stall", 32'(stall), 32'd0);
        check("mid:mem_req", 32'(mem_if.mem_req), 32'd0);
        check("mid:mem_we", 32'(mem_if.mem_we), 32'd0);
        check("mid:mem_addr", mem_if.mem_addr, 32'h0);
        check("mid:mem_wdata", mem_if.mem_wdata, 32'h0);
        check("mid:byte_en", 32'(mem_if.mem_byte_en), 32'd0);
        check("mid:rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid:rsp_rdata", rsp_rdata, 32'h0);
        check("mid:exc_mis", 32'(exc_misaligned), 32'd0);
        check("mid:exc_bus", 32'(exc_bus_error), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post:no_rsp", 32'(rsp_valid), 32'd0);
        run_vec(vecs[0]);

        check("final:sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
